tqvp_periph_initiator: RTL and testbench

//  Bus initiator for the TinyQV peripheral port: the host-side counterpart of a tqvp_* responder.

---
 rtl/tqvp_periph_initiator_if.sv | 24 ++
 rtl/tqvp_periph_initiator.sv | 158 +++++++++++++++
 tb/tb_tqvp_periph_initiator.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tqvp_periph_initiator_if.sv
// Request/response handshake bundle between a host and the TinyQV peripheral initiator.
// The master modport is the host side; the slave modport is the initiator side.
interface tqvp_periph_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/tqvp_periph_initiator.sv
// Host-side initiator for the TinyQV peripheral port: turns one request into a sized
// write/read strobe, waits for data_ready on reads (with timeout) and returns a response.
module tqvp_periph_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  tqvp_periph_initiator_if.slave        bus,
  output logic [7:0]                    err_count,
  output logic [5:0]                    p_address,
  output logic [31:0]                   p_data_in,
  output logic [1:0]                    p_data_write_n,
  output logic [1:0]                    p_data_read_n,
  input  logic [31:0]                   p_data_out,
  input  logic                          p_data_ready
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

  localparam logic [7:0] TimeoutLimit = TIMEOUT_CYCLES[7:0];

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [5:0]  p_address_q, p_address_d;
  logic [31:0] p_data_in_q, p_data_in_d;
  logic [1:0]  write_n_q, write_n_d;
  logic [1:0]  read_n_q, read_n_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        accept;
  logic        enter_err;
  logic [31:0] rdata_masked;

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign err_count      = err_count_q;
  assign p_address      = p_address_q;
  assign p_data_in      = p_data_in_q;
  assign p_data_write_n = write_n_q;
  assign p_data_read_n  = read_n_q;

  // rsp_valid rises one cycle after entering RESP, giving the two-edge accept-to-response latency
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;
    p_address_d = p_address_q;
    p_data_in_d = p_data_in_q;
    write_n_d   = write_n_q;
    read_n_d    = read_n_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    enter_err   = 1'b0;
    accept      = (state_q == IDLE) && req_ready_q && bus.req_valid;

    case (size_q)
      2'b00:   rdata_masked = {24'd0, p_data_out[7:0]};
      2'b01:   rdata_masked = {16'd0, p_data_out[15:0]};
      default: rdata_masked = p_data_out;
    endcase

    case (state_q)
      IDLE: begin
        if (accept) begin
          p_address_d = bus.req_addr;
          p_data_in_d = bus.req_wdata;
          size_d      = bus.req_size;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
          if (bus.req_size == 2'b11) begin
            rsp_err_d = 1'b1;
            enter_err = 1'b1;
            state_d   = RESP;
          end else if (bus.req_write) begin
            write_n_d = bus.req_size;
            state_d   = WRITE;
          end else begin
            read_n_d = bus.req_size;
            cnt_d    = 8'd1;
            state_d  = READ;
          end
        end
      end
      WRITE: begin
        write_n_d = 2'b11;
        state_d   = RESP;
      end
      READ: begin
        if (p_data_ready) begin
          rsp_rdata_d = rdata_masked;
          read_n_d    = 2'b11;
          state_d     = RESP;
        end else if (cnt_q >= TimeoutLimit) begin
          rsp_err_d = 1'b1;
          enter_err = 1'b1;
          read_n_d  = 2'b11;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);

    if (enter_err && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      err_count_q <= 8'd0;
      p_address_q <= 6'd0;
      p_data_in_q <= 32'd0;
      write_n_q   <= 2'b11;
      read_n_q    <= 2'b11;
      size_q      <= 2'b00;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
      p_address_q <= p_address_d;
      p_data_in_q <= p_data_in_d;
      write_n_q   <= write_n_d;
      read_n_q    <= read_n_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tqvp_periph_initiator.sv
// Directed bench for tqvp_periph_initiator: a table of single transactions with hand-computed
// results, plus sequences for response stall, mid-transaction reset and error-count saturation.
module tb_tqvp_periph_initiator;
  localparam int Timeout = 16;

  typedef struct {
    string       name;
    logic        write;
    logic [1:0]  size;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pdout;
    int          readyDelay;
    int          expWrCycles;
    int          expRdCycles;
    int          expLat;
    logic [31:0] expRdata;
    logic        expErr;
    logic [7:0]  expErrCount;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  err_count;
  logic [5:0]  p_address;
  logic [31:0] p_data_in;
  logic [1:0]  p_data_write_n;
  logic [1:0]  p_data_read_n;
  logic [31:0] p_data_out;
  logic        p_data_ready;
  int          errors = 0;
  int          checks = 0;

  tqvp_periph_initiator_if bus ();

  tqvp_periph_initiator #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .err_count      (err_count),
    .p_address      (p_address),
    .p_data_in      (p_data_in),
    .p_data_write_n (p_data_write_n),
    .p_data_read_n  (p_data_read_n),
    .p_data_out     (p_data_out),
    .p_data_ready   (p_data_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReqReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic txn_t mkTxn(input string n, input logic w, input logic [1:0] s,
                                 input logic [5:0] a, input logic [31:0] wd, input logic [31:0] pd,
                                 input int dly, input int wr, input int rd, input int lat,
                                 input logic [31:0] rdata, input logic err, input logic [7:0] ec);
    txn_t t;
    t.name = n; t.write = w; t.size = s; t.addr = a; t.wdata = wd; t.pdout = pd;
    t.readyDelay = dly; t.expWrCycles = wr; t.expRdCycles = rd; t.expLat = lat;
    t.expRdata = rdata; t.expErr = err; t.expErrCount = ec;
    return t;
  endfunction

  // One transaction: request, watch strobes while answering data_ready, then consume the response
  task automatic applyStimulus(input txn_t v);
    bit ok;
    bit gotRsp;
    int wrAny, wrGood, rdAny, rdGood, lat;
    wrAny = 0; wrGood = 0; rdAny = 0; rdGood = 0; lat = 0; gotRsp = 1'b0;
    waitReqReady(ok);
    checkOutput({v.name, ".reqReady"}, 32'(ok), 32'd1);
    if (!ok) return;
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_size  = v.size;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    p_data_out    = v.pdout;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = ~v.addr;
    bus.req_wdata = ~v.wdata;
    bus.req_size  = ~v.size;
    checkOutput({v.name, ".pAddress"}, 32'(p_address), 32'(v.addr));
    checkOutput({v.name, ".pDataIn"}, p_data_in, v.wdata);
    for (int i = 0; i < 60; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        gotRsp = 1'b1;
        break;
      end
      if (p_data_write_n !== 2'b11) begin
        wrAny++;
        if (p_data_write_n === v.size) wrGood++;
      end
      if (p_data_read_n !== 2'b11) begin
        rdAny++;
        if (p_data_read_n === v.size) rdGood++;
      end
      p_data_ready = (v.readyDelay >= 0) && (p_data_read_n !== 2'b11) && (rdAny == v.readyDelay + 1);
      tick();
      lat++;
    end
    p_data_ready = 1'b0;
    checkOutput({v.name, ".rspSeen"}, 32'(gotRsp), 32'd1);
    checkOutput({v.name, ".latency"}, lat, v.expLat);
    checkOutput({v.name, ".writeStrobeCycles"}, wrAny, v.expWrCycles);
    checkOutput({v.name, ".readStrobeCycles"}, rdAny, v.expRdCycles);
    checkOutput({v.name, ".strobeValue"}, wrGood + rdGood, wrAny + rdAny);
    checkOutput({v.name, ".rdata"}, bus.rsp_rdata, v.expRdata);
    checkOutput({v.name, ".err"}, 32'(bus.rsp_err), 32'(v.expErr));
    checkOutput({v.name, ".errCount"}, 32'(err_count), 32'(v.expErrCount));
    checkOutput({v.name, ".reqReadyInResp"}, 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checkOutput({v.name, ".rspDropped"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({v.name, ".reqReadyAfter"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic issueIllegal();
    bit ok;
    bit gotRsp;
    gotRsp = 1'b0;
    waitReqReady(ok);
    if (!ok) begin
      checkOutput("sat.reqReady", 32'(ok), 32'd1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b11;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        gotRsp = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("sat.rspSeen", 32'(gotRsp), 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t vecs[10];
    bit   ok;
    int   stable;
    int   quiet;

    vecs[0] = mkTxn("wr32",      1'b1, 2'b10, 6'h18, 32'h0000_03A5, 32'h0,          -1, 1, 0,  2, 32'h0,          1'b0, 8'd0);
    vecs[1] = mkTxn("rd8",       1'b0, 2'b00, 6'h24, 32'h0,          32'h1234_5678,  0, 0, 1,  2, 32'h0000_0078, 1'b0, 8'd0);
    vecs[2] = mkTxn("rd16dly5",  1'b0, 2'b01, 6'h10, 32'h0,          32'hDEAD_BEEF,  5, 0, 6,  7, 32'h0000_BEEF, 1'b0, 8'd0);
    vecs[3] = mkTxn("rd32tmo",   1'b0, 2'b10, 6'h33, 32'h0,          32'hFFFF_FFFF, -1, 0, 16, 17, 32'h0,         1'b1, 8'd1);
    vecs[4] = mkTxn("rdIllegal", 1'b0, 2'b11, 6'h07, 32'h0,          32'h5555_5555, -1, 0, 0,  1, 32'h0,          1'b1, 8'd2);
    vecs[5] = mkTxn("wr8",       1'b1, 2'b00, 6'h3F, 32'hCAFE_F00D, 32'h0,          -1, 1, 0,  2, 32'h0,          1'b0, 8'd2);
    vecs[6] = mkTxn("rd32last",  1'b0, 2'b10, 6'h02, 32'h0,          32'hA5A5_5A5A, 15, 0, 16, 17, 32'hA5A5_5A5A, 1'b0, 8'd2);
    vecs[7] = mkTxn("wrIllegal", 1'b1, 2'b11, 6'h2A, 32'h1234_5678, 32'h0,          -1, 0, 0,  1, 32'h0,          1'b1, 8'd3);
    vecs[8] = mkTxn("rd16dly2",  1'b0, 2'b01, 6'h0C, 32'h0,          32'h8001_7FFE,  2, 0, 3,  4, 32'h0000_7FFE, 1'b0, 8'd3);
    vecs[9] = mkTxn("wr16",      1'b1, 2'b01, 6'h01, 32'hFFFF_0000, 32'h0,          -1, 1, 0,  2, 32'h0,          1'b0, 8'd3);

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = 6'd0;
    bus.req_wdata = 32'd0;
    bus.rsp_ready = 1'b0;
    p_data_out    = 32'd0;
    p_data_ready  = 1'b0;
    tick();
    tick();
    checkOutput("reset.reqReady", 32'(bus.req_ready), 32'd0);
    checkOutput("reset.rspValid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset.rspRdata", bus.rsp_rdata, 32'd0);
    checkOutput("reset.rspErr", 32'(bus.rsp_err), 32'd0);
    checkOutput("reset.errCount", 32'(err_count), 32'd0);
    checkOutput("reset.pAddress", 32'(p_address), 32'd0);
    checkOutput("reset.pDataIn", p_data_in, 32'd0);
    checkOutput("reset.writeN", 32'(p_data_write_n), 32'd3);
    checkOutput("reset.readN", 32'(p_data_read_n), 32'd3);
    rst = 1'b0;
    tick();
    checkOutput("reset.reqReadyAfter", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Response held off for 10 cycles while new requests and peripheral data are waved at it
    waitReqReady(ok);
    checkOutput("stall.reqReady", 32'(ok), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = 6'h05;
    p_data_out    = 32'h0000_00C3;
    tick();
    bus.req_valid = 1'b0;
    p_data_ready  = 1'b1;
    tick();
    p_data_ready  = 1'b0;
    tick();
    checkOutput("stall.rspValid", 32'(bus.rsp_valid), 32'd1);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_size  = 2'b10;
      bus.req_addr  = 6'h3C;
      bus.req_wdata = 32'hBAD0_0000 + 32'(i);
      p_data_out    = $urandom;
      p_data_ready  = 1'b1;
      if (bus.rsp_valid === 1'b1 && bus.rsp_rdata === 32'hC3 && bus.rsp_err === 1'b0 &&
          bus.req_ready === 1'b0 && p_data_write_n === 2'b11 && p_data_read_n === 2'b11 &&
          p_address === 6'h05)
        stable++;
      tick();
    end
    bus.req_valid = 1'b0;
    p_data_ready  = 1'b0;
    checkOutput("stall.stableCycles", stable, 32'd10);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checkOutput("stall.rspDropped", 32'(bus.rsp_valid), 32'd0);
    checkOutput("stall.noStrayWrite", 32'(p_data_write_n), 32'd3);
    checkOutput("stall.addrKept", 32'(p_address), 32'h05);
    checkOutput("stall.errCount", 32'(err_count), 32'd3);

    // Reset landing in the third read strobe cycle
    waitReqReady(ok);
    checkOutput("midrst.reqReady", 32'(ok), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 6'h11;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    checkOutput("midrst.readNCycle3", 32'(p_data_read_n), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst.readN", 32'(p_data_read_n), 32'd3);
    checkOutput("midrst.writeN", 32'(p_data_write_n), 32'd3);
    checkOutput("midrst.rspValid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midrst.errCount", 32'(err_count), 32'd0);
    checkOutput("midrst.reqReady", 32'(bus.req_ready), 32'd0);
    checkOutput("midrst.pAddress", 32'(p_address), 32'd0);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rsp_valid === 1'b0 && p_data_read_n === 2'b11) quiet++;
    end
    checkOutput("midrst.noPartialRsp", quiet, 32'd20);
    checkOutput("midrst.idleReady", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 254; i++) issueIllegal();
    checkOutput("sat.errCount254", 32'(err_count), 32'd254);
    issueIllegal();
    checkOutput("sat.errCount255", 32'(err_count), 32'd255);
    for (int i = 0; i < 45; i++) issueIllegal();
    checkOutput("sat.errCountHeld", 32'(err_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
